// File: rtl/atm_client_sequencer.sv
// Host-side sequencer that walks an ATM controller through one transaction
// (authenticate, select operation, complete) and holds the result until the host takes it.
module atm_client_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [3:0]  IDLE_ACC       = 4'hF,
    parameter logic        LANG           = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_acc,
    input  logic [13:0] req_pin,
    input  logic [13:0] req_new_pin,
    input  logic [15:0] req_amount,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic        rsp_success,
    output logic [31:0] rsp_balance,
    output logic [15:0] txn_count,
    output logic [3:0]  acc_num,
    output logic [13:0] pin,
    output logic [13:0] newPin,
    output logic [15:0] amount,
    output logic [2:0]  operation,
    output logic        language,
    input  logic [2:0]  atm_state,
    input  logic        atm_success,
    input  logic [31:0] atm_balance
);

    localparam logic [2:0] AtmWaiting = 3'd0;
    localparam logic [2:0] AtmAuth    = 3'd1;
    localparam logic [2:0] AtmMenu    = 3'd2;

    localparam logic [1:0] StatusOk       = 2'd0;
    localparam logic [1:0] StatusAuthFail = 2'd1;
    localparam logic [1:0] StatusTimeout  = 2'd2;
    localparam logic [1:0] StatusBadOp    = 2'd3;

    localparam logic [7:0] TimeoutLim = TIMEOUT_CYCLES[7:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_AUTH,
        S_MENU,
        S_OP,
        S_DONE,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        seen_auth_q, seen_auth_d;
    logic [3:0]  acc_q, acc_d;
    logic [13:0] pin_q, pin_d;
    logic [13:0] new_pin_q, new_pin_d;
    logic [15:0] amount_q, amount_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  status_q, status_d;
    logic        success_q, success_d;
    logic [31:0] balance_q, balance_d;
    logic [15:0] txn_count_q, txn_count_d;

    logic [7:0] timer_inc;
    logic       timeout;
    logic       waiting;
    logic       op_valid;

    assign timer_inc = timer_q + 8'd1;
    // The phase ends on the cycle its count reaches the limit, so a phase lasts at most
    // TIMEOUT_CYCLES cycles; a real ATM transition in that same cycle still wins.
    assign timeout   = (timer_inc == TimeoutLim);
    assign waiting   = (state_q == S_AUTH) || (state_q == S_MENU) || (state_q == S_OP);
    assign op_valid  = (req_op >= 3'd3) && (req_op <= 3'd6);

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        seen_auth_d = seen_auth_q;
        acc_d       = acc_q;
        pin_d       = pin_q;
        new_pin_d   = new_pin_q;
        amount_d    = amount_q;
        op_d        = op_q;
        status_d    = status_q;
        success_d   = success_q;
        balance_d   = balance_q;
        txn_count_d = txn_count_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    acc_d       = req_acc;
                    pin_d       = req_pin;
                    new_pin_d   = req_new_pin;
                    amount_d    = req_amount;
                    op_d        = req_op;
                    seen_auth_d = 1'b0;
                    if (op_valid) begin
                        state_d = S_AUTH;
                    end else begin
                        state_d   = S_RESP;
                        status_d  = StatusBadOp;
                        success_d = 1'b0;
                        balance_d = '0;
                    end
                end
            end
            S_AUTH: begin
                if (atm_state == AtmAuth) begin
                    seen_auth_d = 1'b1;
                end
                if (atm_state == AtmMenu) begin
                    state_d = S_MENU;
                end else if (atm_state == AtmWaiting && seen_auth_q) begin
                    state_d   = S_RESP;
                    status_d  = StatusAuthFail;
                    success_d = 1'b0;
                    balance_d = atm_balance;
                end else if (timeout) begin
                    state_d   = S_RESP;
                    status_d  = StatusTimeout;
                    success_d = 1'b0;
                    balance_d = '0;
                end
            end
            S_MENU: begin
                if (atm_state == op_q) begin
                    state_d = S_OP;
                end else if (timeout) begin
                    state_d   = S_RESP;
                    status_d  = StatusTimeout;
                    success_d = 1'b0;
                    balance_d = '0;
                end
            end
            S_OP: begin
                if (atm_state == AtmWaiting) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d   = S_RESP;
                    status_d  = StatusTimeout;
                    success_d = 1'b0;
                    balance_d = '0;
                end
            end
            S_DONE: begin
                state_d   = S_RESP;
                status_d  = StatusOk;
                success_d = atm_success;
                balance_d = atm_balance;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    txn_count_d = txn_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (waiting && (state_d == state_q)) begin
            timer_d = timer_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            seen_auth_q <= 1'b0;
            acc_q       <= '0;
            pin_q       <= '0;
            new_pin_q   <= '0;
            amount_q    <= '0;
            op_q        <= '0;
            status_q    <= '0;
            success_q   <= 1'b0;
            balance_q   <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            seen_auth_q <= seen_auth_d;
            acc_q       <= acc_d;
            pin_q       <= pin_d;
            new_pin_q   <= new_pin_d;
            amount_q    <= amount_d;
            op_q        <= op_d;
            status_q    <= status_d;
            success_q   <= success_d;
            balance_q   <= balance_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_status  = status_q;
    assign rsp_success = success_q;
    assign rsp_balance = balance_q;
    assign txn_count   = txn_count_q;
    assign language    = LANG;

    always_comb begin
        acc_num   = IDLE_ACC;
        pin       = '0;
        newPin    = '0;
        amount    = '0;
        operation = '0;
        if (waiting) begin
            acc_num = acc_q;
            pin     = pin_q;
            newPin  = new_pin_q;
            amount  = amount_q;
        end
        if (state_q == S_MENU || state_q == S_OP) begin
            operation = op_q;
        end
    end

endmodule
